// File: rtl/hash_pkg.sv
// Shared constants and state encoding for the hash requester.
package hash_pkg;

   localparam int WORD_W      = 32;
   localparam int N_MSG_WORDS = 16;
   localparam int N_DIG_WORDS = 4;
   localparam int START_HOLD  = 2;
   localparam int TIMEOUT_MAX = 255;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      START_HI = 3'd2,
      WAIT     = 3'd3,
      COLLECT  = 3'd4,
      OUT      = 3'd5
   } state_e;

   // Plain-vector aliases of the enum, for code that keeps state in logic [2:0].
   localparam logic [2:0] S_IDLE     = IDLE;
   localparam logic [2:0] S_LOAD     = LOAD;
   localparam logic [2:0] S_START_HI = START_HI;
   localparam logic [2:0] S_WAIT     = WAIT;
   localparam logic [2:0] S_COLLECT  = COLLECT;
   localparam logic [2:0] S_OUT      = OUT;

endpackage

// File: rtl/hash_requester.sv
// Hash requester: accepts a 512-bit message, writes it word by word into the
// engine's message memory, pulses start, then assembles the four 32-bit
// digest words returned by the engine and offers them downstream.
module hash_requester
   import hash_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         msg_valid,
   output logic         msg_ready,
   input  logic [511:0] msg_data,
   output logic         mem_wr,
   output logic [3:0]   mem_addr,
   output logic [31:0]  mem_data,
   output logic         start,
   input  logic         dataOutValid,
   input  logic [31:0]  hashWord,
   output logic         digest_valid,
   input  logic         digest_ready,
   output logic [127:0] digest,
   output logic         err_timeout,
   output logic         err_frag
);

   // Terminal counter values; each counter stops or leaves its state here.
   localparam logic [3:0] WCNT_LAST = 4'(N_MSG_WORDS - 1);
   localparam logic       SCNT_LAST = 1'(START_HOLD - 1);
   localparam logic [1:0] DCNT_LAST = 2'(N_DIG_WORDS - 1);
   localparam logic [7:0] TCNT_MAX  = 8'(TIMEOUT_MAX);
   // Last WAIT cycle: the counter reaches TIMEOUT_MAX on the edge that ends it.
   localparam logic [7:0] TCNT_LAST = 8'(TIMEOUT_MAX - 1);

   logic [2:0]   state_q;
   logic [2:0]   state_d;
   logic [3:0]   wcnt_q;
   logic         scnt_q;
   logic [1:0]   dcnt_q;
   logic [7:0]   tcnt_q;
   logic [511:0] msg_q;
   logic [127:0] digest_q;
   logic         err_timeout_q;
   logic         err_frag_q;

   logic accept;
   logic wait_timeout;
   logic frag;

   assign accept       = (state_q == S_IDLE) && msg_valid;
   assign wait_timeout = (state_q == S_WAIT) && !dataOutValid && (tcnt_q == TCNT_LAST);
   assign frag         = (state_q == S_COLLECT) && !dataOutValid;

   // Next-state selection from the present state and the counters.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (msg_valid) state_d = S_LOAD;
         end
         S_LOAD: begin
            if (wcnt_q == WCNT_LAST) state_d = S_START_HI;
         end
         S_START_HI: begin
            if (scnt_q == SCNT_LAST) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (dataOutValid)            state_d = S_COLLECT;
            else if (tcnt_q == TCNT_LAST) state_d = S_IDLE;
         end
         S_COLLECT: begin
            if (!dataOutValid)            state_d = S_IDLE;
            else if (dcnt_q == DCNT_LAST) state_d = S_OUT;
         end
         S_OUT: begin
            if (digest_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Memory word counter: walks 0..15 through LOAD and parks at 0 elsewhere.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
      end else if (state_q == S_LOAD) begin
         if (wcnt_q == WCNT_LAST) wcnt_q <= '0;
         else                     wcnt_q <= wcnt_q + 4'd1;
      end else begin
         wcnt_q <= '0;
      end
   end

   // Start-hold counter: counts the START_HI cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         scnt_q <= 1'b0;
      end else if (state_q == S_START_HI) begin
         if (scnt_q == SCNT_LAST) scnt_q <= 1'b0;
         else                     scnt_q <= scnt_q + 1'b1;
      end else begin
         scnt_q <= 1'b0;
      end
   end

   // Timeout counter: cleared on the way into WAIT, saturates at TIMEOUT_MAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         tcnt_q <= '0;
      end else if (state_q == S_WAIT) begin
         if (tcnt_q != TCNT_MAX) tcnt_q <= tcnt_q + 8'd1;
      end else begin
         tcnt_q <= '0;
      end
   end

   // Digest word counter: index of the next word to capture in COLLECT.
   always_ff @(posedge clk) begin
      if (rst) begin
         dcnt_q <= '0;
      end else if ((state_q == S_WAIT) && dataOutValid) begin
         dcnt_q <= 2'd1;
      end else if ((state_q == S_COLLECT) && dataOutValid) begin
         if (dcnt_q == DCNT_LAST) dcnt_q <= '0;
         else                     dcnt_q <= dcnt_q + 2'd1;
      end else if (state_q != S_COLLECT) begin
         dcnt_q <= '0;
      end else begin
         dcnt_q <= '0;
      end
   end

   // Message latch: captured once per accepted message, held for the LOAD walk.
   always_ff @(posedge clk) begin
      if (rst)         msg_q <= '0;
      else if (accept) msg_q <= msg_data;
   end

   // Digest assembly: word 0 in WAIT restarts the digest, words 1..3 fill it,
   // and a fragmented burst wipes whatever was gathered.
   always_ff @(posedge clk) begin
      if (rst) begin
         digest_q <= '0;
      end else if ((state_q == S_WAIT) && dataOutValid) begin
         digest_q <= {96'd0, hashWord};
      end else if ((state_q == S_COLLECT) && dataOutValid) begin
         digest_q[{dcnt_q, 5'd0} +: WORD_W] <= hashWord;
      end else if (frag) begin
         digest_q <= '0;
      end
   end

   // Error pulses: registered so each lasts exactly one cycle after the event.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_timeout_q <= 1'b0;
         err_frag_q    <= 1'b0;
      end else begin
         err_timeout_q <= wait_timeout;
         err_frag_q    <= frag;
      end
   end

   // Moore output decode.
   assign msg_ready    = (state_q == S_IDLE);
   assign mem_wr       = (state_q == S_LOAD);
   assign mem_addr     = wcnt_q;
   assign mem_data     = (state_q == S_LOAD) ? msg_q[{wcnt_q, 5'd0} +: WORD_W] : '0;
   assign start        = (state_q == S_START_HI);
   assign digest_valid = (state_q == S_OUT);
   assign digest       = digest_q;
   assign err_timeout  = err_timeout_q;
   assign err_frag     = err_frag_q;

endmodule

// File: tb/tb_hash_requester.sv
// Directed bench for hash_requester with a timeline model of the expected
// outputs and hand-computed spot checks.
module tb_hash_requester;

   logic         clk = 1'b0;
   logic         rst;
   logic         msg_valid;
   logic         msg_ready;
   logic [511:0] msg_data;
   logic         mem_wr;
   logic [3:0]   mem_addr;
   logic [31:0]  mem_data;
   logic         start;
   logic         dataOutValid;
   logic [31:0]  hashWord;
   logic         digest_valid;
   logic         digest_ready;
   logic [127:0] digest;
   logic         err_timeout;
   logic         err_frag;

   always #5 clk = ~clk;

   hash_requester dut (
      .clk          (clk),
      .rst          (rst),
      .msg_valid    (msg_valid),
      .msg_ready    (msg_ready),
      .msg_data     (msg_data),
      .mem_wr       (mem_wr),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .start        (start),
      .dataOutValid (dataOutValid),
      .hashWord     (hashWord),
      .digest_valid (digest_valid),
      .digest_ready (digest_ready),
      .digest       (digest),
      .err_timeout  (err_timeout),
      .err_frag     (err_frag)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [511:0] mk_msg(input logic [31:0] base, input logic [31:0] step);
      logic [511:0] m;
      m = '0;
      for (int w = 0; w < 16; w++) m[w*32 +: 32] = base + step * w;
      return m;
   endfunction

   // Timeline model: m_t counts cycles since the accepting edge (1 = first
   // cycle after it). Cycles 1..16 write, 17..18 start, 19 onwards wait for
   // the engine; the wait gives up after its 255th cycle.
   bit          m_live = 0;
   bit          m_busy = 0;
   bit          m_coll = 0;
   bit          m_out  = 0;
   int          m_t    = 0;
   int          m_nd   = 0;
   logic [511:0] m_msg = '0;
   logic [31:0] m_dig [4];
   bit          m_eto  = 0;
   bit          m_efr  = 0;

   always @(posedge clk) begin
      m_eto = 0;
      m_efr = 0;
      if (rst) begin
         m_live = 1; m_busy = 0; m_coll = 0; m_out = 0; m_t = 0; m_nd = 0;
         m_msg = '0;
         for (int k = 0; k < 4; k++) m_dig[k] = '0;
      end else if (m_out) begin
         if (digest_ready) m_out = 0;
      end else if (!m_busy) begin
         if (msg_valid) begin
            m_busy = 1; m_t = 1; m_msg = msg_data;
         end
      end else if (m_t < 19) begin
         m_t++;
      end else if (!m_coll) begin
         if (dataOutValid) begin
            for (int k = 0; k < 4; k++) m_dig[k] = '0;
            m_dig[0] = hashWord; m_nd = 1; m_coll = 1; m_t++;
         end else if (m_t - 19 == 254) begin
            m_eto = 1; m_busy = 0;
         end else begin
            m_t++;
         end
      end else begin
         if (dataOutValid) begin
            m_dig[m_nd] = hashWord;
            m_nd++;
            if (m_nd == 4) begin
               m_out = 1; m_busy = 0; m_coll = 0;
            end
         end else begin
            m_efr = 1; m_busy = 0; m_coll = 0; m_nd = 0;
            for (int k = 0; k < 4; k++) m_dig[k] = '0;
         end
      end
   end

   int nwr = 0;
   int nst = 0;

   // Per-cycle comparison against the model, just after each rising edge.
   always @(posedge clk) begin
      #1;
      if (m_live) begin
         bit e_wr;
         bit e_st;
         e_wr = m_busy && (m_t >= 1) && (m_t <= 16);
         e_st = m_busy && (m_t >= 17) && (m_t <= 18);
         chk("msg_ready", 128'(msg_ready), 128'(!m_busy && !m_out));
         chk("mem_wr", 128'(mem_wr), 128'(e_wr));
         if (e_wr) begin
            chk("mem_addr", 128'(mem_addr), 128'(m_t - 1));
            chk("mem_data", 128'(mem_data), 128'(m_msg[(m_t-1)*32 +: 32]));
         end
         chk("start", 128'(start), 128'(e_st));
         chk("digest_valid", 128'(digest_valid), 128'(m_out));
         chk("digest", digest, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
         chk("err_timeout", 128'(err_timeout), 128'(m_eto));
         chk("err_frag", 128'(err_frag), 128'(m_efr));
      end
      if (mem_wr === 1'b1) nwr++;
      if (start === 1'b1)  nst++;
   end

   task automatic send_msg(input logic [511:0] m);
      msg_valid = 1'b1;
      msg_data  = m;
      @(negedge clk);
      msg_valid = 1'b0;
      msg_data  = '0;
   endtask

   // Returns at the falling edge of the first cycle after start drops.
   task automatic wait_start_fall();
      int b;
      b = 0;
      while (start !== 1'b1 && b < 40) begin @(negedge clk); b++; end
      if (b >= 40) chk("start_rise_timeout", 128'd1, 128'd0);
      b = 0;
      while (start === 1'b1 && b < 5) begin @(negedge clk); b++; end
      if (b >= 5) chk("start_fall_timeout", 128'd1, 128'd0);
   endtask

   task automatic engine(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input int n);
      logic [31:0] ws [4];
      ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
      for (int i = 0; i < n; i++) begin
         dataOutValid = 1'b1;
         hashWord     = ws[i];
         @(negedge clk);
      end
      dataOutValid = 1'b0;
      hashWord     = '0;
   endtask

   initial begin
      int cnt;
      rst = 1'b1; msg_valid = 1'b0; msg_data = '0; dataOutValid = 1'b0;
      hashWord = '0; digest_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_msg_ready", 128'(msg_ready), 128'd1);
      chk("rst_mem_wr", 128'(mem_wr), 128'd0);
      chk("rst_start", 128'(start), 128'd0);
      chk("rst_digest_valid", 128'(digest_valid), 128'd0);
      chk("rst_digest", digest, 128'd0);

      // Basic message and four-word digest.
      nwr = 0; nst = 0;
      send_msg(mk_msg(32'h1000_0000, 32'd1));
      chk("load_first_addr", 128'(mem_addr), 128'd0);
      chk("load_first_data", 128'(mem_data), 128'h1000_0000);
      wait_start_fall();
      engine(32'hA, 32'hB, 32'hC, 32'hD, 4);
      chk("basic_writes", 128'(nwr), 128'd16);
      chk("basic_start_cycles", 128'(nst), 128'd2);
      chk("basic_digest_valid", 128'(digest_valid), 128'd1);
      chk("basic_digest", digest, 128'h0000000D_0000000C_0000000B_0000000A);

      // Backpressure on the digest with stray inputs in OUT.
      for (int i = 0; i < 10; i++) begin
         msg_valid    = (i == 3);
         msg_data     = {16{32'hDEAD_BEEF}};
         dataOutValid = (i == 5);
         hashWord     = 32'h5555_5555;
         @(negedge clk);
         chk("hold_digest", digest, 128'h0000000D_0000000C_0000000B_0000000A);
         chk("hold_msg_ready", 128'(msg_ready), 128'd0);
      end
      msg_valid = 1'b0; msg_data = '0; dataOutValid = 1'b0; hashWord = '0;
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;
      chk("release_msg_ready", 128'(msg_ready), 128'd1);
      chk("release_digest_valid", 128'(digest_valid), 128'd0);

      // Ignored handshakes during LOAD and WAIT.
      nwr = 0;
      send_msg(mk_msg(32'h2000_0000, 32'h0000_0100));
      for (int i = 0; i < 6; i++) begin
         msg_valid    = i[0];
         msg_data     = {16{32'hFFFF_0000}};
         dataOutValid = !i[0];
         hashWord     = 32'h7777_0000 + 32'(i);
         @(negedge clk);
      end
      msg_valid = 1'b0; msg_data = '0; dataOutValid = 1'b0; hashWord = '0;
      wait_start_fall();
      for (int i = 0; i < 4; i++) begin
         msg_valid = i[0];
         msg_data  = {16{32'h0BAD_0BAD}};
         @(negedge clk);
      end
      msg_valid = 1'b0; msg_data = '0;
      engine(32'hE1, 32'hE2, 32'hE3, 32'hE4, 4);
      chk("ignore_writes", 128'(nwr), 128'd16);
      chk("ignore_digest", digest, 128'h000000E4_000000E3_000000E2_000000E1);
      digest_ready = 1'b1;
      @(negedge clk);
      digest_ready = 1'b0;

      // Timeout with no engine response.
      send_msg(mk_msg(32'h4000_0000, 32'd4));
      wait_start_fall();
      cnt = 0;
      while (err_timeout !== 1'b1 && cnt < 300) begin @(negedge clk); cnt++; end
      chk("timeout_cycles", 128'(cnt), 128'd255);
      chk("timeout_msg_ready", 128'(msg_ready), 128'd1);
      @(negedge clk);
      chk("timeout_pulse_width", 128'(err_timeout), 128'd0);

      // Fragmented digest burst.
      send_msg(mk_msg(32'h5000_0000, 32'd5));
      wait_start_fall();
      engine(32'h11, 32'h22, 32'h0, 32'h0, 2);
      @(negedge clk);
      chk("frag_pulse", 128'(err_frag), 128'd1);
      chk("frag_msg_ready", 128'(msg_ready), 128'd1);
      chk("frag_digest", digest, 128'd0);
      chk("frag_no_valid", 128'(digest_valid), 128'd0);
      @(negedge clk);
      chk("frag_pulse_width", 128'(err_frag), 128'd0);

      // Reset in the middle of LOAD, then a full reload.
      send_msg(mk_msg(32'h6000_0000, 32'd6));
      repeat (7) @(negedge clk);
      chk("midload_addr", 128'(mem_addr), 128'd7);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midload_rst_wr", 128'(mem_wr), 128'd0);
      chk("midload_rst_start", 128'(start), 128'd0);
      chk("midload_rst_ready", 128'(msg_ready), 128'd1);
      nwr = 0;
      send_msg(mk_msg(32'h3000_0000, 32'd1));
      chk("reload_addr", 128'(mem_addr), 128'd0);
      chk("reload_data", 128'(mem_data), 128'h3000_0000);
      wait_start_fall();
      chk("reload_writes", 128'(nwr), 128'd16);
      engine(32'h1, 32'h2, 32'h3, 32'h4, 4);
      chk("reload_digest", digest, 128'h00000004_00000003_00000002_00000001);

      // Reset while the digest is being offered.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      digest_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      digest_ready = 1'b0;
      chk("outrst_digest", digest, 128'd0);
      chk("outrst_valid", 128'(digest_valid), 128'd0);
      chk("outrst_ready", 128'(msg_ready), 128'd1);
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hash_requester.md
HASH_REQUESTER -- requirements
Module: hash_requester

Interface
REQ-001 The block SHALL have these ports, clock and reset first: clk, input, 1, single system clock, all logic on its rising edge.
REQ-002 The block SHALL have rst, input, 1; one clock; reset is synchronous and active-high.
REQ-003 The block SHALL have msg_valid, input, 1, message offered.
REQ-004 The block SHALL have msg_ready, output, 1, message accepted when both are high.
REQ-005 The block SHALL have msg_data, input, 512, word w at bits [32w+31:32w].
REQ-006 The block SHALL have mem_wr, output, 1, message-memory write strobe.
REQ-007 The block SHALL have mem_addr, output, 4, message-memory word address.
REQ-008 The block SHALL have mem_data, output, 32, message-memory write data.
REQ-009 The block SHALL have start, output, 1, hash-engine start request.
REQ-010 The block SHALL have dataOutValid, input, 1, engine digest word valid.
REQ-011 The block SHALL have hashWord, input, 32, engine digest word.
REQ-012 The block SHALL have digest_valid, output, 1, assembled digest available.
REQ-013 The block SHALL have digest_ready, input, 1, downstream accepts the digest.
REQ-014 The block SHALL have digest, output, 128, assembled digest.
REQ-015 The block SHALL have err_timeout, output, 1, one-cycle pulse.
REQ-016 The block SHALL have err_frag, output, 1, one-cycle pulse.

Function
REQ-017 The FSM SHALL use states IDLE, LOAD, START_HI, WAIT, COLLECT and OUT.
REQ-018 All outputs except digest, err_timeout and err_frag SHALL be decoded from the present state and counters only (Moore).
REQ-019 In IDLE: msg_ready=1. On msg_valid&msg_ready, the block SHALL latch msg_data and go to LOAD. Otherwise it stays in IDLE.
REQ-020 In LOAD the block SHALL hold mem_wr=1 for exactly 16 consecutive cycles.
REQ-021 In LOAD, mem_addr SHALL equal the word counter and count 0..15 ascending.
REQ-022 In LOAD, mem_data SHALL equal latched word mem_addr.
REQ-023 After the cycle with address 15 the block SHALL go to START_HI.
REQ-024 In START_HI the block SHALL hold start=1 for exactly 2 cycles, then go to WAIT. The engine waits for start to deassert before running.
REQ-025 In WAIT: start=0, and an 8-bit timeout counter cleared on WAIT entry SHALL increment each cycle.
REQ-026 In WAIT, dataOutValid=1 SHALL capture hashWord as digest word 0 and go to COLLECT.
REQ-027 If the timeout counter reaches 255 with no dataOutValid, the block SHALL pulse err_timeout for 1 cycle and return to IDLE.
REQ-028 COLLECT SHALL capture digest words 1, 2 and 3 on the next 3 cycles, which must all have dataOutValid=1.
REQ-029 Digest word k SHALL be placed at digest[32k+31:32k].
REQ-030 If dataOutValid=0 in any COLLECT cycle, the block SHALL pulse err_frag for 1 cycle, discard the partial digest and go to IDLE.
REQ-031 In OUT the block SHALL hold digest_valid=1 with digest stable until digest_ready=1.
REQ-032 On the digest_valid&digest_ready transfer the block SHALL go to IDLE, so msg_ready=1 on the next cycle.
REQ-033 dataOutValid SHALL be ignored in IDLE, LOAD, START_HI and OUT.
REQ-034 msg_valid SHALL be ignored outside IDLE.
REQ-035 End-to-end latency: message accept edge E0 -> mem writes E0+1..E0+16 -> start high E0+17..E0+18 -> WAIT from E0+19.
REQ-036 All counters SHALL be sized exactly, with no wrap beyond their terminal values: 4-bit word counter, 2-bit digest counter, 8-bit timeout counter.

Reset
REQ-037 rst sampled high at a clock edge SHALL, from any state including mid-LOAD, mid-COLLECT and OUT, force state IDLE.
REQ-038 Reset SHALL clear all counters, the message latch and digest to 0.
REQ-039 Reset SHALL force mem_wr=0, start=0, digest_valid=0, err_timeout=0 and err_frag=0.
REQ-040 After the reset cycle, msg_ready SHALL be 1.
REQ-041 rst SHALL take priority over every simultaneous handshake.

Structure
REQ-042 Package hash_pkg SHALL hold the state enum, WORD_W=32, N_MSG_WORDS=16, N_DIG_WORDS=4, START_HOLD=2 and TIMEOUT_MAX=255.
REQ-043 hash_requester SHALL be a single module with no sub-modules: next-state logic, output decode, counters and datapath registers only.

Verification
REQ-044 Message with word w = 32'h1000_0000+w, then engine words 32'hA, 32'hB, 32'hC, 32'hD on 4 consecutive cycles -> mem writes addr 0..15 with matching data, start high exactly 2 cycles, digest=128'h0000000D_0000000C_0000000B_0000000A.
REQ-045 digest_ready held low 10 cycles after digest_valid -> digest stable, msg_ready=0 throughout; ready high -> IDLE next cycle.
REQ-046 No dataOutValid after start falls -> err_timeout pulse exactly 1 cycle after 255 WAIT cycles; IDLE follows.
REQ-047 dataOutValid drops after 2 words -> err_frag 1-cycle pulse, digest_valid never asserted, msg_ready=1 next cycle.
REQ-048 rst asserted at mem_addr=7 -> mem_wr=0 and start=0 next cycle; new message is fully reloaded from addr 0.
REQ-049 msg_valid pulses during LOAD and WAIT, and dataOutValid during LOAD -> ignored, with no change to writes or digest.
